// File: rtl/mips_run_ctrl.sv
// Run controller for the MIPS core: gates the core clock-enable from start until halt, self-loop or cycle budget.
// All outputs registered; cpu_en is a pure state decode, so one edge from start/clear to enable change.
module mips_run_ctrl #(
  parameter int                    DATA_WIDTH       = 32,
  parameter int                    CNT_WIDTH        = 16,
  parameter int                    MAX_CYCLES       = 752,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR       = DATA_WIDTH'(32'hFC00_0000),
  parameter int                    SELF_LOOP_CYCLES = 3,
  parameter int                    DRAIN_CYCLES     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  instr_valid,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] instr,
  output logic                  cpu_en,
  output logic                  done,
  output logic                  halted,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  instr_count
);

  localparam int LOOP_W = $clog2(SELF_LOOP_CYCLES + 1) + 1;
  localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [LOOP_W-1:0]    LOOP_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cyc, w_cyc_nxt, w_cyc_inc;
  logic [CNT_WIDTH-1:0]  r_ins, w_ins_nxt, w_ins_inc;
  logic [DATA_WIDTH-1:0] r_pc_q, w_pc_q_nxt;
  logic [LOOP_W-1:0]     r_loop, w_loop_nxt, w_loop_inc;
  logic [DRN_W-1:0]      r_drain, w_drain_nxt;
  logic                  r_halted, w_halted_nxt;
  logic                  r_timeout, w_timeout_nxt;
  logic                  w_pc_same, w_loop_evt, w_halt_evt, w_to_evt;

  // Counters saturate rather than wrap so a long run never looks short.
  assign w_cyc_inc  = (r_cyc == CNT_MAX) ? r_cyc : r_cyc + CNT_WIDTH'(1);
  assign w_ins_inc  = (r_ins == CNT_MAX) ? r_ins : r_ins + CNT_WIDTH'(1);
  assign w_loop_inc = (r_loop == LOOP_MAX) ? r_loop : r_loop + LOOP_W'(1);
  assign w_pc_same  = (pc == r_pc_q);

  always_comb begin
    w_state_nxt   = r_state;
    w_cyc_nxt     = r_cyc;
    w_ins_nxt     = r_ins;
    w_pc_q_nxt    = r_pc_q;
    w_loop_nxt    = r_loop;
    w_drain_nxt   = r_drain;
    w_halted_nxt  = r_halted;
    w_timeout_nxt = r_timeout;
    w_loop_evt    = 1'b0;
    w_halt_evt    = 1'b0;
    w_to_evt      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_RUN;
          w_cyc_nxt     = '0;
          w_ins_nxt     = '0;
          w_pc_q_nxt    = '0;
          w_loop_nxt    = '0;
          w_drain_nxt   = '0;
          w_halted_nxt  = 1'b0;
          w_timeout_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cyc_nxt = w_cyc_inc;
          if (instr_valid) begin
            w_ins_nxt  = w_ins_inc;
            w_pc_q_nxt = pc;
            w_loop_nxt = w_pc_same ? w_loop_inc : '0;
          end
          w_loop_evt = (SELF_LOOP_CYCLES > 0) && instr_valid && w_pc_same &&
                       (32'(w_loop_inc) == SELF_LOOP_CYCLES);
          w_halt_evt = (instr_valid && (instr == HALT_INSTR)) || w_loop_evt;
          w_to_evt   = (32'(w_cyc_inc) == MAX_CYCLES);
          // Halt outranks a timeout landing on the same edge.
          if (w_halt_evt) begin
            if (DRAIN_CYCLES > 0) begin
              w_state_nxt = S_DRAIN;
              w_drain_nxt = DRN_W'(DRAIN_CYCLES);
            end else begin
              w_state_nxt  = S_DONE;
              w_halted_nxt = 1'b1;
            end
          end else if (w_to_evt) begin
            w_state_nxt   = S_DONE;
            w_timeout_nxt = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cyc_nxt   = w_cyc_inc;
          w_drain_nxt = r_drain - DRN_W'(1);
          if (instr_valid) begin
            w_ins_nxt = w_ins_inc;
          end
          if (r_drain <= DRN_W'(1)) begin
            w_state_nxt  = S_DONE;
            w_halted_nxt = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (clear) begin
          w_state_nxt   = S_IDLE;
          w_halted_nxt  = 1'b0;
          w_timeout_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cyc     <= '0;
      r_ins     <= '0;
      r_pc_q    <= '0;
      r_loop    <= '0;
      r_drain   <= '0;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cyc     <= w_cyc_nxt;
      r_ins     <= w_ins_nxt;
      r_pc_q    <= w_pc_q_nxt;
      r_loop    <= w_loop_nxt;
      r_drain   <= w_drain_nxt;
      r_halted  <= w_halted_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign cpu_en      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign halted      = r_halted;
  assign timeout     = r_timeout;
  assign cycle_count = r_cyc;
  assign instr_count = r_ins;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: four differently parameterised instances share one stimulus stream
// and are compared every cycle against a per-instance behavioural run model.
module tb_mips_run_ctrl;
  localparam int N = 4;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst, start, clear, iv;
  logic [31:0] pc, ins;
  logic        en [N];
  logic        dn [N];
  logic        hl [N];
  logic        to [N];
  logic [15:0] cc [3];
  logic [15:0] ic [3];
  logic [3:0]  cc3, ic3;

  int checks = 0;
  int errors = 0;
  int en0cnt;

  always #5 clk = ~clk;

  mips_run_ctrl #(.CNT_WIDTH(16), .MAX_CYCLES(8), .SELF_LOOP_CYCLES(3), .DRAIN_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .instr_valid(iv), .pc(pc), .instr(ins),
    .cpu_en(en[0]), .done(dn[0]), .halted(hl[0]), .timeout(to[0]), .cycle_count(cc[0]), .instr_count(ic[0]));
  mips_run_ctrl #(.CNT_WIDTH(16), .MAX_CYCLES(5), .SELF_LOOP_CYCLES(3), .DRAIN_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .instr_valid(iv), .pc(pc), .instr(ins),
    .cpu_en(en[1]), .done(dn[1]), .halted(hl[1]), .timeout(to[1]), .cycle_count(cc[1]), .instr_count(ic[1]));
  mips_run_ctrl #(.CNT_WIDTH(16), .MAX_CYCLES(12), .SELF_LOOP_CYCLES(3), .DRAIN_CYCLES(0)) u2 (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .instr_valid(iv), .pc(pc), .instr(ins),
    .cpu_en(en[2]), .done(dn[2]), .halted(hl[2]), .timeout(to[2]), .cycle_count(cc[2]), .instr_count(ic[2]));
  mips_run_ctrl #(.CNT_WIDTH(4), .MAX_CYCLES(20), .SELF_LOOP_CYCLES(0), .DRAIN_CYCLES(0)) u3 (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .instr_valid(iv), .pc(pc), .instr(ins),
    .cpu_en(en[3]), .done(dn[3]), .halted(hl[3]), .timeout(to[3]), .cycle_count(cc3), .instr_count(ic3));

  function automatic int pmax(input int k);
    case (k) 0: return 8; 1: return 5; 2: return 12; default: return 20; endcase
  endfunction
  function automatic int pself(input int k);
    return (k == 3) ? 0 : 3;
  endfunction
  function automatic int pdrain(input int k);
    return (k == 0) ? 2 : 0;
  endfunction
  function automatic int plim(input int k);
    return (k == 3) ? 15 : 65535;
  endfunction
  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Reference run model: a run is "running", "draining" or "finished"; neither means idle.
  bit          m_run [N];
  bit          m_drn [N];
  bit          m_done [N];
  bit          m_hlt [N];
  bit          m_to [N];
  int          m_cyc [N];
  int          m_ins [N];
  int          m_left [N];
  int          m_rep [N];
  logic [31:0] m_pc [N];

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_run[k] = 0; m_drn[k] = 0; m_done[k] = 0; m_hlt[k] = 0; m_to[k] = 0;
      m_cyc[k] = 0; m_ins[k] = 0; m_left[k] = 0; m_rep[k] = 0; m_pc[k] = '0;
    end
  endtask

  task automatic model_edge();
    bit rpt, halt;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < N; k++) begin
      if (m_done[k]) begin
        if (clear) begin m_done[k] = 0; m_hlt[k] = 0; m_to[k] = 0; end
      end else if (m_run[k] || m_drn[k]) begin
        if (clear) begin
          m_run[k] = 0; m_drn[k] = 0;
        end else begin
          m_cyc[k] = sat(m_cyc[k] + 1, plim(k));
          if (iv) m_ins[k] = sat(m_ins[k] + 1, plim(k));
          if (m_run[k]) begin
            rpt = iv && (pc == m_pc[k]);
            if (iv) begin
              m_rep[k] = rpt ? m_rep[k] + 1 : 0;
              m_pc[k]  = pc;
            end
            halt = (iv && ins == HALT) || (pself(k) > 0 && rpt && m_rep[k] == pself(k));
            if (halt) begin
              m_run[k] = 0;
              if (pdrain(k) > 0) begin m_drn[k] = 1; m_left[k] = pdrain(k); end
              else begin m_done[k] = 1; m_hlt[k] = 1; end
            end else if (m_cyc[k] == pmax(k)) begin
              m_run[k] = 0; m_done[k] = 1; m_to[k] = 1;
            end
          end else begin
            m_left[k]--;
            if (m_left[k] == 0) begin m_drn[k] = 0; m_done[k] = 1; m_hlt[k] = 1; end
          end
        end
      end else if (start) begin
        m_run[k] = 1; m_cyc[k] = 0; m_ins[k] = 0; m_pc[k] = '0; m_rep[k] = 0;
      end
    end
  endtask

  function automatic logic [31:0] obs_cc(input int k);
    case (k) 0: return 32'(cc[0]); 1: return 32'(cc[1]); 2: return 32'(cc[2]); default: return 32'(cc3); endcase
  endfunction
  function automatic logic [31:0] obs_ic(input int k);
    case (k) 0: return 32'(ic[0]); 1: return 32'(ic[1]); 2: return 32'(ic[2]); default: return 32'(ic3); endcase
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[u%0d] observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk("cpu_en", k, 32'(en[k]), 32'(m_run[k] || m_drn[k]));
      chk("done", k, 32'(dn[k]), 32'(m_done[k]));
      chk("halted", k, 32'(hl[k]), 32'(m_hlt[k]));
      chk("timeout", k, 32'(to[k]), 32'(m_to[k]));
      chk("cycle_count", k, obs_cc(k), 32'(m_cyc[k]));
      chk("instr_count", k, obs_ic(k), 32'(m_ins[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (en[0] === 1'b1) en0cnt++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; iv = 1'b0; pc = '0; ins = '0;
    model_reset();
    #1;
    check_all();
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Budget exhaustion with no instructions; the 4-bit instance saturates instead.
    start = 1'b1; en0cnt = 0;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("t1_en_cycles", 0, 32'(en0cnt), 32'd8);
    chk("t1_timeout", 0, 32'(to[0]), 32'd1);
    chk("t1_halted", 0, 32'(hl[0]), 32'd0);
    chk("t1_cycles", 0, 32'(cc[0]), 32'd8);
    chk("t6_sat_cycles", 3, 32'(cc3), 32'd15);
    chk("t6_sat_running", 3, 32'(en[3]), 32'd1);
    chk("t6_sat_notimeout", 3, 32'(to[3]), 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clear_only_exit", 3, 32'(en[3]), 32'd0);
    tick();

    // Halt instruction on the 5th retire, followed by drain.
    start = 1'b1; en0cnt = 0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iv = 1'b1; pc = 32'(4 * i); ins = (i == 4) ? HALT : 32'h0000_0020;
      tick();
    end
    iv = 1'b0; ins = '0;
    repeat (5) tick();
    chk("t2_en_cycles", 0, 32'(en0cnt), 32'd7);
    chk("t2_halted", 0, 32'(hl[0]), 32'd1);
    chk("t2_cycles", 0, 32'(cc[0]), 32'd7);
    chk("t2_instr_ge5", 0, 32'(ic[0] >= 16'd5), 32'd1);
    chk("t4_halted", 1, 32'(hl[1]), 32'd1);
    chk("t4_timeout", 1, 32'(to[1]), 32'd0);
    chk("t4_cycles", 1, 32'(cc[1]), 32'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_start_ignored", 0, 32'(dn[0]), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clr_done", 0, 32'(dn[0]), 32'd0);
    chk("t6_clr_halted", 0, 32'(hl[0]), 32'd0);
    chk("t6_clr_count_hold", 0, 32'(cc[0]), 32'd7);

    // Self-loop on PC 0x8.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      iv = 1'b1; pc = (i < 2) ? 32'(4 * i) : 32'h8; ins = 32'h0000_0020;
      tick();
    end
    iv = 1'b0;
    chk("t3_done", 2, 32'(dn[2]), 32'd1);
    chk("t3_halted", 2, 32'(hl[2]), 32'd1);
    chk("t3_cycles", 2, 32'(cc[2]), 32'd6);
    chk("t3_instrs", 2, 32'(ic[2]), 32'd6);
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Reset in the 3rd RUN cycle, then a clean restart.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("t5_restart_cycles", 0, 32'(cc[0]), 32'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Randomised traffic with a small PC set to provoke self-loops.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom % 4) == 0;
      clear = ($urandom % 16) == 0;
      iv    = ($urandom % 4) != 0;
      pc    = 32'(4 * ($urandom % 3));
      ins   = (($urandom % 12) == 0) ? HALT : $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
